// File: rtl/audio_frame_sequencer.sv
// ==========================================================================
// audio_frame_sequencer -- I2S-style codec frame sequencer: bclk/lrc
// generation, MSB-first DAC shift-out and ADC capture.
// Option: AUDIO_UNDERRUN_HOLD_EN (repeat last word on underrun). Rev 1.0
// ==========================================================================
`default_nettype none

module audio_frame_sequencer #(
  parameter int WIDTH    = 32,
  parameter int BCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             underrun,
  output logic             busy,
  output logic             bclk,
  output logic             daclrc,
  output logic             adclrc,
  output logic             dacdat,
  input  logic             adcdat
);

  localparam int CW = $clog2(WIDTH);
  localparam int DW = $clog2(BCLK_DIV);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(WIDTH / 2 - 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(BCLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LEFT  = 2'd1;
  localparam logic [1:0] S_RIGHT = 2'd2;

  logic [1:0]       state, state_nx;
  logic [DW-1:0]    div_cnt;
  logic [CW-1:0]    bit_cnt;
  logic             lrc;
  logic             rx_load;
  logic [WIDTH-1:0] tx_sh, rx_sh, hold, fill_word, tx_word;
  logic             tick, rise, fall, boundary, start, stop;

  assign tick     = (state != S_IDLE) && (div_cnt == DIV_MAX);
  assign rise     = tick && !bclk;
  assign fall     = tick && bclk;
  assign boundary = fall && (bit_cnt == LAST_BIT);
  assign start    = en && ((state == S_IDLE) || boundary);
  assign stop     = boundary && !en;
  // tx_ready high means the holding register is empty
  assign tx_word  = tx_ready ? fill_word : hold;

  assign daclrc = lrc;
  assign adclrc = lrc;
  assign dacdat = tx_sh[WIDTH-1];

`ifdef AUDIO_UNDERRUN_HOLD_EN
  logic [WIDTH-1:0] last_tx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_tx <= '0;
    else if (start) last_tx <= tx_word;
  end

  assign fill_word = last_tx;
`else
  assign fill_word = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (en) state_nx = S_LEFT;
      S_LEFT:  if (fall && (bit_cnt == HALF_M1)) state_nx = S_RIGHT;
      S_RIGHT: if (boundary) state_nx = en ? S_LEFT : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrc     <= 1'b0;
      tx_sh   <= '0;
      rx_sh   <= '0;
    end else if (start) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrc     <= 1'b1;
      tx_sh   <= tx_word;
    end else if (stop) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrc     <= 1'b0;
      tx_sh   <= '0;
    end else if (state != S_IDLE) begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) bclk <= ~bclk;
      if (rise) rx_sh <= {rx_sh[WIDTH-2:0], adcdat};
      if (fall) begin
        bit_cnt <= bit_cnt + CW'(1);
        tx_sh   <= {tx_sh[WIDTH-2:0], 1'b0};
        if (bit_cnt == HALF_M1) lrc <= 1'b0;
      end
    end
  end

  // A load coinciding with frame start lands after the hold was consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready <= 1'b1;
      hold     <= '0;
      rx_load  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rx_load  <= rise && (bit_cnt == LAST_BIT);
      rx_valid <= rx_load;
      if (rx_load) rx_data <= rx_sh;
      underrun <= start && tx_ready;
      if (tx_valid && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end else if (start) begin
        tx_ready <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_frame_sequencer.sv
// ==========================================================================
// tb_audio_frame_sequencer -- randomized bench with a codec model and a
// frame-level reference of the holding register and expected words. Rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_audio_frame_sequencer;

  localparam int WIDTH      = 32;
  localparam int BCLK_DIV   = 2;
  localparam int FRAME_CLKS = 2 * BCLK_DIV * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             adcdat = 1'b0;
  logic             tx_ready, rx_valid, underrun, busy;
  logic             bclk, daclrc, adclrc, dacdat;
  logic [WIDTH-1:0] rx_data;

  audio_frame_sequencer #(.WIDTH(WIDTH), .BCLK_DIV(BCLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .underrun(underrun), .busy(busy), .bclk(bclk), .daclrc(daclrc),
    .adclrc(adclrc), .dacdat(dacdat), .adcdat(adcdat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] actual,
                       input logic [WIDTH-1:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference model and codec state
  logic [WIDTH-1:0] exp_tx_q[$];
  logic [WIDTH-1:0] exp_rx_q[$];
  logic [WIDTH-1:0] hold, last_tx, hs_data, adc_cur, dac_sh, word, fill;
  logic [WIDTH-1:0] adc_fix_val = 32'h1234_ABCD;
  bit   hold_full, hs_pend, frame_start, exp_under, adc_fixed = 1'b1;
  bit   prev_lrc, prev_bclk, prev_busy;
  int   cyc, start_cyc, idx, rise_idx, frame_cnt, rxv_cnt, under_cnt;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_tx_q.delete();
      exp_rx_q.delete();
      hold_full = 0; hold = '0; last_tx = '0; hs_pend = 0;
      prev_lrc = 0; prev_bclk = 0; prev_busy = 0;
      idx = WIDTH; rise_idx = 0; adcdat = 1'b0;
    end else begin
      frame_start = daclrc && !prev_lrc;
      exp_under   = frame_start && !hold_full;
      check("underrun", underrun, exp_under);
      if (underrun) under_cnt++;
      if (frame_start) begin
        if (prev_busy) check("frame_period", cyc - start_cyc, FRAME_CLKS);
`ifdef AUDIO_UNDERRUN_HOLD_EN
        fill = last_tx;
`else
        fill = '0;
`endif
        word = hold_full ? hold : fill;
        exp_tx_q.push_back(word);
        last_tx   = word;
        hold_full = 0;
        adc_cur   = adc_fixed ? adc_fix_val : $urandom;
        exp_rx_q.push_back(adc_cur);
        start_cyc = cyc; idx = 0; rise_idx = 0;
        frame_cnt++;
      end else if (prev_bclk && !bclk) begin
        idx++;
      end
      if (!prev_bclk && bclk) begin
        if (rise_idx == 0) check("first_rise", cyc - start_cyc, BCLK_DIV);
        dac_sh = {dac_sh[WIDTH-2:0], dacdat};
        if (rise_idx == WIDTH - 1) begin
          if (exp_tx_q.size() == 0) check("dac_extra", 1, 0);
          else check("dac_word", dac_sh, exp_tx_q.pop_front());
        end
        rise_idx++;
      end
      if (prev_lrc && !daclrc) check("lrc_high", cyc - start_cyc, FRAME_CLKS / 2);
      if (prev_busy && !busy) begin
        check("busy_fall", cyc - start_cyc, FRAME_CLKS);
        check("idle_bclk", bclk, 0);
      end
      if (rx_valid) begin
        rxv_cnt++;
        check("rx_time", cyc - start_cyc, BCLK_DIV * (2 * WIDTH - 1) + 1);
        if (exp_rx_q.size() == 0) check("rx_extra", 1, 0);
        else check("rx_data", rx_data, exp_rx_q.pop_front());
      end
      if (hs_pend) begin
        hold = hs_data;
        hold_full = 1;
      end
      check("tx_ready", tx_ready, !hold_full);
      hs_pend = tx_valid && !hold_full;
      hs_data = tx_data;
      adcdat = (idx < WIDTH) ? adc_cur[WIDTH-1-idx] : 1'b0;
      prev_lrc = daclrc; prev_bclk = bclk; prev_busy = busy;
    end
  end

  // All stimulus tasks start and end at posedge+1
  task automatic send_word(input logic [WIDTH-1:0] w);
    int i;
    tx_data = w; tx_valid = 1'b1;
    for (i = 0; i < 2000; i++) begin
      if (tx_ready) break;
      @(posedge clk); #1;
    end
    check("send_wait", i < 2000, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int i;
    for (i = 0; i < 5000; i++) begin
      if (frame_cnt >= target) break;
      @(posedge clk); #1;
    end
    check("frame_wait", frame_cnt >= target, 1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 5000; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    check("idle_wait", busy, 0);
  endtask

  task automatic wait_bit(input int target);
    int i;
    for (i = 0; i < 5000; i++) begin
      if (busy && idx == target) break;
      @(posedge clk); #1;
    end
    check("bit_wait", idx, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bclk"}, bclk, 0);
    check({tag, "_daclrc"}, daclrc, 0);
    check({tag, "_adclrc"}, adclrc, 0);
    check({tag, "_dacdat"}, dacdat, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_rx_data"}, rx_data, 0);
  endtask

  int base, uc0, rv0;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known word and known ADC pattern, two back-to-back frames
    base = frame_cnt;
    send_word(32'hA5A5_3C3C);
    en = 1'b1;
    send_word(32'hA5A5_3C3C);
    wait_frames(base + 2);
    en = 1'b0;
    wait_idle();
    adc_fixed = 1'b0;

    // Underrun: one word, then two starved frames
    base = frame_cnt;
    send_word(32'hDEAD_BEEF);
    uc0 = under_cnt;
    en = 1'b1;
    wait_frames(base + 3);
    en = 1'b0;
    wait_idle();
    check("underrun_count", under_cnt - uc0, 2);

    // Stop request mid-frame still completes the frame
    rv0 = rxv_cnt;
    en = 1'b1;
    wait_bit(5);
    en = 1'b0;
    wait_idle();
    check("rx_after_stop", rxv_cnt - rv0, 1);
    repeat (10) @(posedge clk);
    #1;
    check("bclk_parked", bclk, 0);

    // Load on the frame-start clock is kept for the next frame
    base = frame_cnt;
    en = 1'b1; tx_valid = 1'b1; tx_data = 32'h5A5A_0FF0;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("start_tx_ready", tx_ready, 0);
    check("start_busy", busy, 1);
    wait_frames(base + 2);
    en = 1'b0;
    wait_idle();

    // Random traffic with occasional run gaps
    en = 1'b1;
    for (int i = 0; i < 1800; i++) begin
      tx_valid = ($urandom_range(0, 15) == 0);
      tx_data  = $urandom;
      if ($urandom_range(0, 399) == 0) en = ~en;
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    en = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a frame
    en = 1'b1;
    wait_bit(20);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rv0 = rxv_cnt;
    repeat (200) @(posedge clk);
    #1;
    check("rx_after_abort", rxv_cnt - rv0, 0);

    // Fresh frame after reset: empty hold, fill restarts from zero
    base = frame_cnt;
    en = 1'b1;
    wait_frames(base + 1);
    en = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check("tx_queue_drained", exp_tx_q.size(), 0);
    check("rx_queue_drained", exp_rx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/audio_frame_sequencer.md
AUDIO_FRAME_SEQUENCER -- requirements
Module: audio_frame_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the frame size: left plus right channel bits, MSB-first, left channel in the upper half.
REQ-002 SHALL have parameter BCLK_DIV, default 4, meaning clk cycles per bclk half-period (minimum 2).
REQ-003 SHALL use one clock and an asynchronous active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1 bit: run request.
REQ-007 SHALL have port tx_data, input, WIDTH bits: DAC sample {left,right}.
REQ-008 SHALL have port tx_valid, input, 1 bit: tx_data valid.
REQ-009 SHALL have port tx_ready, output, 1 bit: holding register empty.
REQ-010 SHALL have port rx_data, output, WIDTH bits: captured ADC sample {left,right}.
REQ-011 SHALL have port rx_valid, output, 1 bit: one-clk pulse, rx_data updated.
REQ-012 SHALL have port underrun, output, 1 bit: one-clk pulse, frame started with no tx sample held.
REQ-013 SHALL have port busy, output, 1 bit: high while not IDLE.
REQ-014 SHALL have ports bclk, daclrc, adclrc and dacdat, outputs, 1 bit each: codec serial clock, frame/channel clocks (identical), serial DAC data.
REQ-015 SHALL have port adcdat, input, 1 bit: serial ADC data from codec.

Function
REQ-016 SHALL implement states IDLE, LEFT and RIGHT.
REQ-017 SHALL, in IDLE, hold bclk=0, lrc=0 and dacdat=0, with the divider and bit counter at 0.
REQ-018 SHALL, in IDLE with en=1, on the next clk enter LEFT as a frame start.
REQ-019 SHALL toggle bclk every BCLK_DIV clk outside IDLE, first rising edge BCLK_DIV clk after frame start, giving a period of 2*BCLK_DIV clk.
REQ-020 SHALL, at frame start, set lrc=1, move the holding register to the shift register, set tx_ready=1, drive dacdat=MSB and set bit_cnt=0.
REQ-021 SHALL, on every bclk falling edge, increment bit_cnt, shift left and drive the next dacdat bit in the same clk.
REQ-022 SHALL, at bit_cnt=WIDTH/2, go LEFT->RIGHT with lrc=0.
REQ-023 SHALL, at the falling edge after bit WIDTH-1 (the frame boundary), start a new frame (RIGHT->LEFT) if en=1, else enter IDLE.
REQ-024 SHALL sample adcdat into the rx shift register on every bclk rising edge.
REQ-025 SHALL, one clk after the rising edge of bit WIDTH-1, load rx_data and pulse rx_valid, with no backpressure.
REQ-026 SHALL accept tx_valid&&tx_ready into the holding register and clear tx_ready the next clk.
REQ-027 SHALL give a load that coincides with frame start precedence to frame start; the incoming word is then held for the next frame.
REQ-028 SHALL, at a frame start with an empty holding register, pulse underrun for one clk and send the REQ-039 fill data.
REQ-029 SHALL, when en is deasserted mid-frame, complete the frame fully (dacdat and rx_valid) before entering IDLE.
REQ-030 SHALL keep the held tx word across IDLE.

Reset
REQ-031 SHALL, on rst_n=0, immediately enter IDLE.
REQ-032 SHALL reset bclk, daclrc, adclrc, dacdat, rx_valid, underrun and busy to 0.
REQ-033 SHALL reset tx_ready to 1.
REQ-034 SHALL reset rx_data, the shift registers, the holding register and all counters to 0.
REQ-035 SHALL discard a partial frame aborted by reset, with no rx_valid.

Configuration
REQ-036 SHALL provide macro AUDIO_UNDERRUN_HOLD_EN.
REQ-037 SHALL, with AUDIO_UNDERRUN_HOLD_EN defined, retain the last transmitted word.
REQ-038 SHALL, with AUDIO_UNDERRUN_HOLD_EN defined, repeat that word on underrun (0 if none since reset).
REQ-039 SHALL, without AUDIO_UNDERRUN_HOLD_EN, transmit all zeros on underrun.
REQ-040 SHALL pulse underrun identically in both builds.

Verification (WIDTH=32, BCLK_DIV=2)
REQ-041 SHALL cover: tx_data=0xA5A5_3C3C held, en=1 -> codec model captures 0xA5A5_3C3C; one frame is 128 clk; lrc high for the first 64 clk.
REQ-042 SHALL cover: codec drives 0x1234_ABCD on adcdat -> rx_valid pulses once per frame with rx_data=0x1234_ABCD.
REQ-043 SHALL cover: no tx_valid, en=1 -> underrun pulses each frame; dacdat stays 0 without the macro; with the macro the prior word 0xDEAD_BEEF repeats.
REQ-044 SHALL cover: en=0 at bit 5 -> frame completes, rx_valid pulses, busy falls at the boundary, bclk stays 0.
REQ-045 SHALL cover: tx_valid on the frame-start clk -> word held, tx_ready=0, sent next frame with no loss.
REQ-046 SHALL cover: rst_n low at bit 20 -> all outputs take REQ-032..034 values immediately, with no rx_valid.
